video_ram_arbiter: RTL and testbench

- Shares the single read port of the video cache / packet buffer RAM between two requesters.
- The VGA graphics pipeline has absolute priority and fixed latency.
- A burst reader serves the Ethernet TX path. It reads a contiguous address range only in slots the graphics side leaves idle, and delivers the data through a small valid/ready FIFO.
- Sits between the RAM, the graphics pixel fetch and the TX framer.

---
 rtl/video_ram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_video_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_ram_arbiter.sv
// video_ram_arbiter
//   Shares the single read port of the video / packet-buffer RAM between the
//   VGA pixel fetch (absolute priority, fixed latency, never stalled) and a
//   burst reader feeding the Ethernet TX framer through a small valid/ready
//   FIFO. Burst reads only use cycles the graphics side leaves idle.
//
// Ports
//   clk, rst                     clock, synchronous active-low reset
//   gfx_readclk/gfx_raddr        graphics read request and address
//   gfx_outclk/gfx_out           graphics read data, RAM_LATENCY cycles later
//   burst_start/addr/len         start a burst of len words from addr
//   burst_busy/burst_done        burst in progress / one-cycle completion pulse
//   tx_out/tx_outclk/tx_ready    TX stream (FIFO head, valid, consumer ready)
//   ram_readclk/ram_raddr        RAM read enable and address
//   ram_outclk/ram_out           RAM read data valid and data
module video_ram_arbiter #(
    parameter int RAM_ADDR_LEN  = 10,
    parameter int DATA_LEN      = 12,
    parameter int RAM_LATENCY   = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int BURST_LEN_LEN = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     gfx_readclk,
    input  logic [RAM_ADDR_LEN-1:0]  gfx_raddr,
    output logic                     gfx_outclk,
    output logic [DATA_LEN-1:0]      gfx_out,
    input  logic                     burst_start,
    input  logic [RAM_ADDR_LEN-1:0]  burst_addr,
    input  logic [BURST_LEN_LEN-1:0] burst_len,
    output logic                     burst_busy,
    output logic                     burst_done,
    output logic [DATA_LEN-1:0]      tx_out,
    output logic                     tx_outclk,
    input  logic                     tx_ready,
    output logic                     ram_readclk,
    output logic [RAM_ADDR_LEN-1:0]  ram_raddr,
    input  logic                     ram_outclk,
    input  logic [DATA_LEN-1:0]      ram_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state;
    logic [RAM_ADDR_LEN-1:0]  ptr;
    logic [BURST_LEN_LEN-1:0] remaining;
    logic [CNT_W-1:0]         in_flight;
    logic [CNT_W-1:0]         fifo_count;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [DATA_LEN-1:0]      fifo_mem [FIFO_DEPTH];
    logic [RAM_LATENCY-1:0]   tag_pipe;   // 1 = this slot carried a burst read
    logic [RAM_LATENCY-1:0]   gfx_pipe;   // 1 = this slot carried a graphics read

    logic             tag_out;
    logic [CNT_W:0]   occupied;
    logic             have_credit;
    logic             burst_issue;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;

    assign tag_out = tag_pipe[RAM_LATENCY-1];

    // Words already committed to the FIFO: stored plus still inside the RAM.
    // Issuing only while this is below the depth makes overflow impossible.
    assign occupied    = {1'b0, fifo_count} + {1'b0, in_flight};
    assign have_credit = occupied < (CNT_W+1)'(FIFO_DEPTH);

    assign burst_issue = rst && (state == RUN) && !gfx_readclk
                         && (remaining != '0) && have_credit;

    // Graphics wins the port unconditionally; a burst only fills idle slots.
    assign ram_readclk = gfx_readclk | burst_issue;
    assign ram_raddr   = gfx_readclk ? gfx_raddr : ptr;

    // Returns are steered by the tag recorded at issue time. The graphics
    // pipe additionally hides stale pre-reset returns from the pixel path.
    assign gfx_outclk = ram_outclk & ~tag_out & gfx_pipe[RAM_LATENCY-1];
    assign gfx_out    = ram_out;
    assign fifo_push  = ram_outclk & tag_out;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_pop   = ~fifo_empty & tx_ready;
    assign tx_outclk  = ~fifo_empty;
    assign tx_out     = fifo_empty ? '0 : fifo_mem[rd_ptr];

    assign burst_busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            remaining  <= '0;
            in_flight  <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_pipe   <= '0;
            // Older slots are dropped; a graphics read issued in the reset
            // cycle itself is genuine (the port follows gfx during reset).
            gfx_pipe   <= RAM_LATENCY'(gfx_readclk);
            burst_done <= 1'b0;
        end else begin
            tag_pipe   <= RAM_LATENCY'({tag_pipe, burst_issue});
            gfx_pipe   <= RAM_LATENCY'({gfx_pipe, gfx_readclk});
            in_flight  <= in_flight + CNT_W'(burst_issue) - CNT_W'(fifo_push);
            fifo_count <= fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
            if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            burst_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (burst_start) begin
                        if (burst_len != '0) begin
                            ptr       <= burst_addr;
                            remaining <= burst_len;
                            state     <= RUN;
                        end else begin
                            burst_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (burst_issue) begin
                        ptr       <= ptr + RAM_ADDR_LEN'(1);
                        remaining <= remaining - BURST_LEN_LEN'(1);
                        if (remaining == BURST_LEN_LEN'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((in_flight == '0) && fifo_empty) begin
                        burst_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: FIFO storage is deliberately not reset; occupancy is tracked by
    // the pointers/count, and tx_out is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= ram_out;
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                       !(fifo_push && fifo_full))
        else $error("video_ram_arbiter: FIFO push while full");

endmodule

// File: tb/tb_video_ram_arbiter.sv
// Bench for video_ram_arbiter: RAM model returning addr^0xABC after two
// cycles, a per-cycle scoreboard derived from the arbitration rules, a
// graphics vector table and directed burst sequences, then random traffic.
module tb_video_ram_arbiter;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        gfx_readclk;
    logic [9:0]  gfx_raddr;
    logic        gfx_outclk;
    logic [11:0] gfx_out;
    logic        burst_start;
    logic [9:0]  burst_addr;
    logic [10:0] burst_len;
    logic        burst_busy;
    logic        burst_done;
    logic [11:0] tx_out;
    logic        tx_outclk;
    logic        tx_ready;
    logic        ram_readclk;
    logic [9:0]  ram_raddr;
    logic        ram_outclk;
    logic [11:0] ram_out;

    video_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .gfx_readclk(gfx_readclk), .gfx_raddr(gfx_raddr),
        .gfx_outclk(gfx_outclk), .gfx_out(gfx_out),
        .burst_start(burst_start), .burst_addr(burst_addr), .burst_len(burst_len),
        .burst_busy(burst_busy), .burst_done(burst_done),
        .tx_out(tx_out), .tx_outclk(tx_outclk), .tx_ready(tx_ready),
        .ram_readclk(ram_readclk), .ram_raddr(ram_raddr),
        .ram_outclk(ram_outclk), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    // RAM model: fixed two-cycle read latency, data = address ^ 0xABC.
    logic       rv [LAT] = '{default: 1'b0};
    logic [9:0] ra [LAT] = '{default: 10'h0};
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            rv[i] <= rv[i-1];
            ra[i] <= ra[i-1];
        end
        rv[0] <= ram_readclk;
        ra[0] <= ram_raddr;
    end
    assign ram_outclk = rv[LAT-1];
    assign ram_out    = {2'b00, ra[LAT-1]} ^ 12'hABC;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int n_burst_reads = 0;
    int n_done   = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct { int due; logic [11:0] data; } word_t;
    word_t gfx_q[$];          // graphics returns: cycle they must appear
    word_t tx_q[$];           // burst words: cycle they become visible on TX

    bit         m_active = 1'b0;
    bit         m_done   = 1'b0;
    int         m_rem    = 0;
    int         m_out    = 0;   // issued but not yet consumed by TX
    logic [9:0] m_addr   = '0;

    always @(negedge clk) begin : monitor
        bit exp_issue, act_issue, exp_tv, finish, done_next;
        if (mon_en) begin
            if (gfx_q.size() > 0 && gfx_q[0].due == cyc) begin
                check("gfx_outclk", gfx_outclk, 1);
                check("gfx_out", gfx_out, gfx_q[0].data);
                void'(gfx_q.pop_front());
            end else begin
                check("gfx_outclk_idle", gfx_outclk, 0);
            end
            if (gfx_readclk) begin
                check("gfx_ram_readclk", ram_readclk, 1);
                check("gfx_ram_raddr", ram_raddr, gfx_raddr);
                gfx_q.push_back('{cyc + LAT, {2'b00, gfx_raddr} ^ 12'hABC});
            end

            check("burst_busy", burst_busy, m_active);
            check("burst_done", burst_done, m_done);
            if (burst_done) n_done++;

            exp_issue = rst && m_active && m_rem > 0 && !gfx_readclk && m_out < DEPTH;
            act_issue = ram_readclk && !gfx_readclk;
            if (act_issue) n_burst_reads++;
            check("burst_issue", act_issue, exp_issue);
            if (exp_issue && act_issue) check("burst_raddr", ram_raddr, m_addr);

            exp_tv = tx_q.size() > 0 && tx_q[0].due <= cyc;
            check("tx_outclk", tx_outclk, exp_tv);
            if (exp_tv) check("tx_out", tx_out, tx_q[0].data);

            done_next = 1'b0;
            if (!rst) begin
                m_active = 1'b0; m_rem = 0; m_out = 0; tx_q.delete();
            end else begin
                finish = m_active && m_rem == 0 && m_out == 0;
                if (exp_issue) begin
                    tx_q.push_back('{cyc + LAT + 1, {2'b00, m_addr} ^ 12'hABC});
                    m_addr++; m_rem--; m_out++;
                end
                if (exp_tv && tx_ready) begin
                    void'(tx_q.pop_front());
                    m_out--;
                end
                if (finish) begin
                    m_active  = 1'b0;
                    done_next = 1'b1;
                end else if (!m_active && burst_start) begin
                    if (burst_len == 0) done_next = 1'b1;
                    else begin
                        m_active = 1'b1; m_rem = int'(burst_len); m_addr = burst_addr;
                    end
                end
            end
            m_done = done_next;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [9:0] a, input logic [10:0] len);
        burst_start = 1'b1; burst_addr = a; burst_len = len;
        tick();
        burst_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (burst_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, burst_busy, 0);
        tick();
    endtask

    typedef struct { logic [9:0] addr; logic [11:0] exp; } gvec_t;
    gvec_t gvec [3];

    initial begin
        int r0, d0;
        gvec[0] = '{10'h000, 12'hABC};
        gvec[1] = '{10'h01F, 12'hAA3};
        gvec[2] = '{10'h3FF, 12'h943};

        rst = 1'b0; gfx_readclk = 1'b0; gfx_raddr = '0; burst_start = 1'b0;
        burst_addr = '0; burst_len = '0; tx_ready = 1'b0;
        tick();
        mon_en = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("rst_busy", burst_busy, 0);
        check("rst_done", burst_done, 0);
        check("rst_tx_outclk", tx_outclk, 0);
        check("rst_tx_out", tx_out, 0);
        check("rst_gfx_outclk", gfx_outclk, 0);
        tick();
        rst = 1'b1;
        tick();

        // Graphics only: table of address / expected data.
        for (int i = 0; i < 3; i++) begin
            gfx_readclk = 1'b1; gfx_raddr = gvec[i].addr;
            tick();
            gfx_readclk = 1'b0;
            @(negedge clk);
            check("gvec_not_early", gfx_outclk, 0);
            @(negedge clk);
            check("gvec_outclk", gfx_outclk, 1);
            check("gvec_data", gfx_out, gvec[i].exp);
            check("gvec_no_tx", tx_outclk, 0);
            tick(); tick();
        end

        // Idle burst of three words.
        tx_ready = 1'b1; r0 = n_burst_reads; d0 = n_done;
        start_burst(10'h010, 11'd3);
        wait_idle("idle_burst_end", 40);
        check("idle_reads", n_burst_reads - r0, 3);
        check("idle_done_cnt", n_done - d0, 1);

        // Contention: graphics high for 10 cycles, then alternating.
        r0 = n_burst_reads;
        gfx_readclk = 1'b1; gfx_raddr = 10'($urandom);
        start_burst(10'h100, 11'd5);
        for (int i = 0; i < 9; i++) begin
            gfx_raddr = 10'($urandom);
            tick();
        end
        gfx_readclk = 1'b0;
        check("cont_no_reads", n_burst_reads - r0, 0);
        for (int i = 0; i < 20; i++) begin
            gfx_readclk = (i % 2 == 0); gfx_raddr = 10'($urandom);
            tick();
        end
        gfx_readclk = 1'b0;
        wait_idle("cont_end", 60);
        check("cont_reads", n_burst_reads - r0, 5);

        // Backpressure with address wrap.
        tx_ready = 1'b0; r0 = n_burst_reads;
        start_burst(10'h3FE, 11'd8);
        repeat (12) tick();
        check("bp_stall_reads", n_burst_reads - r0, 4);
        check("bp_busy", burst_busy, 1);
        tx_ready = 1'b1;
        wait_idle("bp_end", 60);
        check("bp_reads", n_burst_reads - r0, 8);

        // Zero-length burst.
        r0 = n_burst_reads; d0 = n_done;
        start_burst(10'h020, 11'd0);
        @(negedge clk);
        check("len0_done", burst_done, 1);
        check("len0_busy", burst_busy, 0);
        tick();
        check("len0_reads", n_burst_reads - r0, 0);
        check("len0_done_cnt", n_done - d0, 1);

        // Start while busy is ignored.
        r0 = n_burst_reads; d0 = n_done;
        start_burst(10'h200, 11'd6);
        tick();
        start_burst(10'h050, 11'd2);
        wait_idle("busy_start_end", 60);
        check("busy_start_reads", n_burst_reads - r0, 6);
        check("busy_start_done_cnt", n_done - d0, 1);

        // Reset mid-burst with two reads in flight.
        d0 = n_done;
        start_burst(10'h300, 11'd6);
        tick(); tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx_outclk", tx_outclk, 0);
        check("mid_rst_busy", burst_busy, 0);
        check("mid_rst_gfx_outclk", gfx_outclk, 0);
        repeat (5) tick();
        check("mid_rst_no_done", n_done - d0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            gfx_readclk = ($urandom_range(0, 99) < 40);
            gfx_raddr   = 10'($urandom);
            tx_ready    = ($urandom_range(0, 99) < 70);
            burst_start = ($urandom_range(0, 99) < 10);
            burst_addr  = 10'($urandom);
            burst_len   = 11'($urandom_range(0, 12));
            tick();
        end
        gfx_readclk = 1'b0; burst_start = 1'b0; tx_ready = 1'b1;
        wait_idle("rand_drain", 200);
        repeat (4) tick();
        check("end_tx_q_empty", tx_q.size(), 0);
        check("end_gfx_q_empty", gfx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
